// File: rtl/spi_master_if.sv
// if_wb: Wishbone bus bundle shared by the IO MMU and its peripheral slaves.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        ack;
  logic        stall;
  modport master (output cyc, stb, we, adr, dat_i, sel, input dat_o, ack, stall);
  modport slave  (input cyc, stb, we, adr, dat_i, sel, output dat_o, ack, stall);
endinterface

// File: rtl/spi_master.sv
// spi_master: Wishbone-slave SPI master, mode 0, MSB first, 8-bit frames, with done interrupt.
module spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd12
) (
  input  logic clk_i,
  input  logic rst_i,
  if_wb.slave  bus,
  output logic sclk,
  output logic mosi,
  input  logic miso,
  output logic sd_ss,
  output logic eth_ss,
  output logic interrupt
);
  typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;
  state_t      state_q, state_d;
  logic        ack_q, ack_d, done_q, done_d, irq_en_q, irq_en_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d, sd_ss_q, sd_ss_d, eth_ss_q, eth_ss_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic [7:0]  div_q, div_d, divw_q, divw_d, tx_q, tx_d, rxshift_q, rxshift_d, rxdata_q, rxdata_d;
  logic [7:0]  divcnt_q, divcnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        busy, req, tick, unused_bus;
  assign busy       = state_q != IDLE;
  assign req        = bus.cyc & bus.stb & ~ack_q;
  assign tick       = divcnt_q == divw_q;
  assign unused_bus = ^{bus.sel, bus.adr[31:1]};
  assign bus.ack    = ack_q;
  assign bus.dat_o  = dat_o_q;
  assign bus.stall  = 1'b0;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign sd_ss      = sd_ss_q;
  assign eth_ss     = eth_ss_q;
  assign interrupt  = done_q & irq_en_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      done_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      sd_ss_q   <= 1'b1;
      eth_ss_q  <= 1'b1;
      div_q     <= DIV_RESET;
      divw_q    <= DIV_RESET;
      tx_q      <= '0;
      rxshift_q <= '0;
      rxdata_q  <= '0;
      divcnt_q  <= '0;
      bitcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_o_q   <= dat_o_d;
      done_q    <= done_d;
      irq_en_q  <= irq_en_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      sd_ss_q   <= sd_ss_d;
      eth_ss_q  <= eth_ss_d;
      div_q     <= div_d;
      divw_q    <= divw_d;
      tx_q      <= tx_d;
      rxshift_q <= rxshift_d;
      rxdata_q  <= rxdata_d;
      divcnt_q  <= divcnt_d;
      bitcnt_q  <= bitcnt_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    ack_d     = req;
    dat_o_d   = !req ? 32'b0 : bus.adr[0] ? {16'b0, div_q, 3'b0, irq_en_q, done_q, eth_ss_q, sd_ss_q, busy}
                                          : {24'b0, rxdata_q};
    done_d    = done_q;
    irq_en_d  = irq_en_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    sd_ss_d   = sd_ss_q;
    eth_ss_d  = eth_ss_q;
    div_d     = div_q;
    divw_d    = divw_q;
    tx_d      = tx_q;
    rxshift_d = rxshift_q;
    rxdata_d  = rxdata_q;
    divcnt_d  = divcnt_q;
    bitcnt_d  = bitcnt_q;
    if (req && bus.we && bus.adr[0]) begin
      sd_ss_d  = bus.dat_i[1];
      eth_ss_d = bus.dat_i[2];
      irq_en_d = bus.dat_i[4];
      div_d    = busy ? div_q : bus.dat_i[15:8];
      done_d   = bus.dat_i[3] ? 1'b0 : done_d;
    end
    if (req && !bus.we && !bus.adr[0]) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (req && bus.we && !bus.adr[0]) begin
          tx_d     = bus.dat_i[7:0];
          divw_d   = div_q;
          done_d   = 1'b0;
          divcnt_d = '0;
          bitcnt_d = '0;
          mosi_d   = bus.dat_i[7];
          state_d  = LEAD;
        end
      end
      LEAD: begin
        divcnt_d = tick ? 8'd0 : divcnt_q + 8'd1;
        if (tick) begin
          sclk_d    = 1'b1;
          rxshift_d = {rxshift_q[6:0], miso};
          state_d   = TRAIL;
        end
      end
      default: begin
        divcnt_d = tick ? 8'd0 : divcnt_q + 8'd1;
        if (tick) begin
          sclk_d = 1'b0;
          // Completion sets done after any same-cycle clear so the set wins.
          if (bitcnt_q == 3'd7) begin
            rxdata_d = rxshift_q;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            mosi_d   = tx_q[3'd6 - bitcnt_q];
            state_d  = LEAD;
          end
        end
      end
    endcase
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Wishbone-slave SPI master (mode 0, MSB first, 8-bit frames).
- Drives the SD-card and Ethernet SPI pins.
- Sits on the IO MMU behind the data bus as a peer of the UART and timer, and consumes the slave port that MMU produces.
- Raises a level interrupt on transfer completion for the interrupt encoder.

Parameters:
- DIV_RESET, 8'd12, reset value of the clock divider. Half SCLK period is DIV+1 clk_i cycles, so the default gives about 385 kHz at 10 MHz, which is safe for SD init.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- bus  interface  -  if_wb.slave. Uses cyc, stb, we, adr, dat_i[31:0], dat_o[31:0] and ack; stall is tied 0 and sel is ignored.
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data out
- miso  input  1  SPI data in
- sd_ss  output  1  SD chip select, active low
- eth_ss  output  1  Ethernet chip select, active low
- interrupt  output  1  level; equals done & irq_en

Behaviour:
- One clock domain; reset is synchronous, active-high.
- Reset values:
  - sclk=0, mosi=0, sd_ss=1, eth_ss=1, interrupt=0, ack=0, dat_o=0.
  - busy=0, done=0, irq_en=0, div=DIV_RESET, rxdata=0.
- Bus handshake:
  - ack is registered: ack <= cyc & stb & ~ack. This gives a one-cycle pulse one cycle after the request, with no double ack.
  - Register side effects occur on the same edge that sets ack.
  - dat_o is valid while ack=1.
- Register select is adr[0] (word address):
  - 0 = DATA
  - 1 = CTRL
- DATA write:
  - If busy=0: latch tx=dat_i[7:0] and divw=div, clear done, set busy, enter LEAD with bitcnt=0 and divcnt=0, and set mosi=dat_i[7].
  - If busy=1: the write is ignored (still acked).
- DATA read:
  - Returns {24'b0, rxdata}.
  - Clears done.
- CTRL read returns {16'b0, div[7:0], 3'b0, irq_en, done, eth_ss, sd_ss, busy}.
- CTRL write:
  - bit1 -> sd_ss; bit2 -> eth_ss; bit4 -> irq_en. These update immediately, even while busy.
  - bit3 = 1 clears done (write-1-to-clear).
  - bits[15:8] -> div. Ignored while busy; a running transfer always uses its latched divw.
- State machine:
  - IDLE:
    - sclk=0.
    - Leaves only on an accepted DATA write.
  - LEAD (sclk low):
    - divcnt increments every cycle.
    - When divcnt==divw: sclk<=1, rxshift<={rxshift[6:0],miso}, divcnt<=0, go to TRAIL.
  - TRAIL (sclk high):
    - When divcnt==divw: sclk<=0, divcnt<=0.
    - If bitcnt==7: rxdata<={rxshift[6:0] as updated}, busy<=0, done<=1, go to IDLE. mosi holds its last bit.
    - Otherwise: bitcnt++, mosi<=tx[6-bitcnt], go to LEAD.
- Frame timing:
  - One frame is exactly 16*(divw+1) cycles from the accepting edge to the edge where busy falls.
  - Exactly 8 rising sclk edges occur per frame.
- Simultaneous events:
  - Frame completion in the same cycle as a done clear (CTRL W1C or DATA read): set wins, so done=1.
  - A DATA read in the completion cycle returns the old rxdata.
  - A DATA write in the completion cycle sees busy=1 and is ignored.
- Chip selects are software-controlled only; the block never toggles them itself.
- rst_i asserted mid-frame aborts the frame immediately. All state returns to reset values on that edge and no done is raised.

Test Plan:
- Reset -> CTRL reads 0x00000C06; sclk=0; sd_ss=eth_ss=1; interrupt=0.
- CTRL write 0x00000010 (div=0, irq_en=1, sd_ss=0), then DATA write 0xA5 with miso looped to mosi:
  - 8 sclk pulses of 1 cycle high / 1 cycle low.
  - busy drops 16 cycles after the accepting edge.
  - interrupt=1; DATA read returns 0x000000A5 and clears interrupt.
- div=3, DATA write 0x3C, miso tied 1:
  - Half period is 4 cycles and the frame is 64 cycles.
  - mosi follows 0,0,1,1,1,1,0,0, stable across each rising edge.
  - rxdata reads 0xFF.
- DATA write 0x55 during an active frame -> ignored (ack still given); the frame completes with the original byte. A CTRL div write during the frame is also ignored, and CTRL[15:8] is unchanged.
- Completion edge coincides with a CTRL W1C write -> done reads 1 afterwards. A separate W1C afterwards clears it, and interrupt falls.
- rst_i pulsed at bitcnt=4 -> next cycle sclk=0, busy=0, done=0, sd_ss=1, div=12. Bus transfers are immediately functional again.
